mem_access_unit: RTL

- MEM-stage memory interface directly downstream of the pipeline datapath. Consumes data_adr, data_out, mem_read and mem_write; returns load data on data_in.
- Converts a single-cycle memory request into a req/ack handshake with a variable-latency data memory.
- Stalls the pipeline while an access is outstanding.
- Detects misaligned word accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit.
// Turns a single-cycle load/store from the pipeline into a req/ack handshake
// with a variable-latency data memory. The pipeline is stalled while the access
// is outstanding. Misaligned word accesses are dropped with a one-cycle
// align_err pulse. Accesses that never complete are aborted after TIMEOUT busy
// cycles and raise the sticky bus_err flag.
module mem_access_unit #(
    parameter int                DATA_W  = 32,
    parameter int                TIMEOUT = 255,
    parameter int                CNT_W   = 8,
    parameter logic [DATA_W-1:0] ERR_VAL = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] data_adr,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    output logic              stall,
    output logic              align_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A word access is only legal on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [DATA_W-1:0] adr);
        return (adr[1:0] == 2'b00);
    endfunction

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                align_err_q, align_err_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                access_s;
    logic                stall_s;

    assign access_s  = mem_read | mem_write;
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, datapath latching and combinational stall generation.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_in_d   = data_in_q;
        align_err_d = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        stall_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    if (is_word_aligned(data_adr)) begin
                        // Stall in the request cycle so EX/MEM holds the instruction.
                        stall_s = 1'b1;
                        state_d = S_BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = data_adr;
                        wdata_d = data_out;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        align_err_d = 1'b1;
                        // A simultaneous store wins, so only a pure load sees ERR_VAL.
                        if (mem_read && !mem_write) begin
                            data_in_d = ERR_VAL;
                        end else begin
                            data_in_d = data_in_q;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_s = 1'b1;
                if (mem_ack) begin
                    // Ack has priority over a timeout in the same cycle.
                    req_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_DONE;
                    if (!we_q) begin
                        data_in_d = mem_rdata;
                    end else begin
                        data_in_d = data_in_q;
                    end
                end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = S_DONE;
                    if (!we_q) begin
                        data_in_d = ERR_VAL;
                    end else begin
                        data_in_d = data_in_q;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_DONE: begin
                // Inputs still belong to the completed instruction.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= {DATA_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            data_in_q   <= {DATA_W{1'b0}};
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_in_q   <= data_in_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Stall is forced low while reset is held so every output clears at once.
    assign stall     = stall_s & ~rst;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign data_in   = data_in_q;
    assign align_err = align_err_q;
    assign bus_err   = bus_err_q;

endmodule
